modexp_param: RTL
=================

# modexp_param

Parametrised modular exponentiator computing result = base^exp mod prime by right-to-left square-and-multiply. It is built on an interleaved shift-add modular multiplier, so no wide divider is needed. It is the generic successor of the fixed 100-bit exponentiator used in the Diffie-Hellman key-exchange datapath. It adds a start/busy/done handshake, input latching, error reporting and a selectable constant-time mode.

## Interface
- W, 100, operand/modulus width in bits
- EW, 101, exponent width in bits
- CONST_TIME, 1, 1 = fixed iteration count with dummy multiplies; 0 = skip zero bits and stop after exponent MSB
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- base  in  W  base, any value (may be >= prime)
- exp_in  in  EW  exponent
- prime  in  W  modulus
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; result/err valid from this cycle
- result  out  W  base^exp mod prime; holds until next done
- err  out  1  set with done when prime == 0; cleared on next accepted start

## Operation
- Reset values: busy=0, done=0, result=0, err=0, FSM=IDLE, all working registers 0.
- Accept: start=1 in IDLE latches base, exp_in and prime into internal registers. Later input changes are ignored. start while busy is ignored (no queueing).
- prime == 0: go directly to DONE with err=1 and result=0.
- States:
  - IDLE -> PREP on start.
  - PREP: B = base mod p via mm(base, 1). R = (p==1) ? 0 : 1. Then -> MUL.
  - MUL: if exponent bit i is 1, R = mm(R, B). If bit i is 0 and CONST_TIME=1, run mm(R, B) into a discarded register. If bit i is 0 and CONST_TIME=0, skip.
  - SQR: B = mm(B, B).
  - NEXT: i++. Go to DONE if i == EW, or if CONST_TIME=0 and no set bits remain above i. Otherwise -> MUL.
  - DONE: result = R, pulse done, -> IDLE.
- exp = 0: R stays at its init value, so result = 1 (0 when prime == 1). With CONST_TIME=0 the block goes to DONE straight after PREP.
- Sub-multiplier mm(a, b), requires b < p:
  - MSB-first over the W bits of a.
  - acc = 2·acc + a[j]·b, then conditionally subtract p up to twice.
  - acc is W+2 bits wide.
  - Invariant: acc < p after every step. Output = acc, which is < p.
- All intermediate operands stay < p < 2^W. No W·W-bit product is ever formed.

## Timing
- mm latency: start pulse -> done pulse exactly W+1 cycles later. Each mm issue occupies W+2 top-level FSM cycles.
- CONST_TIME=1: done asserts exactly 1 + (W+2)·(1 + 2·EW) cycles after the start edge, independent of data.
- CONST_TIME=0: latency is 1 + (W+2)·(1 + m + popcount(exp)), where m = index of exponent MSB + 1 (m=0 for exp=0).
- prime == 0: done asserts 2 cycles after the start edge.
- start may be re-asserted in the cycle after done; it is accepted in IDLE.
- Reset mid-operation: all state is cleared immediately and asynchronously. The pending operation is lost and no done is produced. The old result is not retained.
- done and busy are never high in the same cycle.

## Structure
- Shared package (dh_pkg): default W/EW constants and the FSM state enum (IDLE, PREP, MUL, SQR, NEXT, DONE).
- One sub-module, mod_mult_interleaved, parameterised by W.
  - Ports: clk, rst, start, a, b, p, busy, done, y.
  - Also reused by the key-exchange top level.
- Top FSM, exponent bit index counter ($clog2(EW+1) bits) and latched operand registers live in modexp_param.

## Test plan
- W=16, EW=8, CONST_TIME=1: base=4, exp=13, prime=497 -> result=445, err=0, done at exactly cycle 307 after start.
- CONST_TIME=0, W=16, EW=8: base=2, exp=10, prime=1000 -> result=24, done at 1+18·(1+4+2)=127 cycles.
- exp=0, base=9, prime=11 -> result=1. The same case with prime=1 -> result=0. prime=0 -> err=1, result=0, done 2 cycles after start.
- base=500 >= prime=497, exp=1 -> result=3. Default W=100, EW=101: random vectors checked against a reference model, including prime = 2^100−3.
- Hold start high and pulse it mid-operation -> ignored, single done. Assert rst mid-operation -> outputs zero immediately, no done. A new start after reset completes correctly.

Source files
------------

// File: rtl/dh_pkg.sv
// dh_pkg: shared constants and FSM state encoding for the modular exponentiation datapath.
package dh_pkg;

    localparam int DH_W  = 100;
    localparam int DH_EW = 101;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        MUL,
        SQR,
        NEXT,
        DONE
    } modexp_state_t;

endpackage

// File: rtl/mod_mult_interleaved.sv
// mod_mult_interleaved: y = a*b mod p, MSB-first interleaved shift-add with two
// conditional subtracts per step, so no full product or divider is ever built.
// b must already be reduced below p; a may hold any W-bit value.
module mod_mult_interleaved
    import dh_pkg::*;
#(
    parameter int W = DH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] y
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0] a_sh;
    logic [W-1:0] b_reg;
    logic [W-1:0] p_reg;
    logic [W+1:0] acc;
    logic [CW-1:0] cnt;
    logic [W+1:0] p_ext;
    logic [W+1:0] dbl_add;
    logic [W+1:0] sub1;
    logic [W+1:0] sub2;

    // One interleaved step: double, add b if the current a bit is set, then pull back below p.
    always_comb begin
        p_ext   = {2'b00, p_reg};
        dbl_add = (acc << 1) + (a_sh[W-1] ? {2'b00, b_reg} : '0);
        sub1    = (dbl_add >= p_ext) ? (dbl_add - p_ext) : dbl_add;
        sub2    = (sub1 >= p_ext) ? (sub1 - p_ext) : sub1;
    end

    assign y = acc[W-1:0];

    // Load operands on start, then walk the W bits of a; done pulses with the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_reg <= '0;
            p_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                a_sh  <= a;
                b_reg <= b;
                p_reg <= p;
                acc   <= '0;
                cnt   <= CW'(W);
                busy  <= 1'b1;
            end else if (busy) begin
                acc  <= sub2;
                a_sh <= a_sh << 1;
                cnt  <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/modexp_param.sv
// modexp_param: result = base^exp mod prime, right-to-left square-and-multiply
// on top of the interleaved modular multiplier, with an optional constant-time mode.
module modexp_param
    import dh_pkg::*;
#(
    parameter int W          = DH_W,
    parameter int EW         = DH_EW,
    parameter int CONST_TIME = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exp_in,
    input  logic [W-1:0]  prime,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          err
);

    localparam int IW = $clog2(EW + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(EW);

    modexp_state_t state;

    logic [W-1:0]  base_reg;
    logic [EW-1:0] exp_reg;
    logic [W-1:0]  prime_reg;
    logic [W-1:0]  r_reg;
    logic [W-1:0]  b_reg;
    logic [IW-1:0] idx;

    logic          mm_start;
    logic [W-1:0]  mm_a;
    logic [W-1:0]  mm_b;
    logic          mm_busy;
    logic          mm_done;
    logic [W-1:0]  mm_y;
    logic          mm_finished;

    logic [IW-1:0] sel_idx;
    logic [EW-1:0] rem;
    logic          cur_bit;
    logic          at_end;
    logic          do_mul;

    mod_mult_interleaved #(
        .W (W)
    ) u_mm (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .p     (prime_reg),
        .busy  (mm_busy),
        .done  (mm_done),
        .y     (mm_y)
    );

    assign mm_finished = mm_done && !mm_busy;

    // Operand routing: PREP reduces base via base*1, MUL forms R*B, SQR forms B*B.
    always_comb begin
        mm_a = r_reg;
        mm_b = b_reg;
        case (state)
            PREP:    begin mm_a = base_reg; mm_b = W'(1); end
            SQR:     mm_a = b_reg;
            default: ;
        endcase
    end

    // Bit-advance decision, evaluated on the completing edge so stepping to the next bit costs no cycle.
    always_comb begin
        sel_idx = idx;
        if (state == PREP) begin
            sel_idx = '0;
        end else if (state == SQR) begin
            sel_idx = idx + IW'(1);
        end
        rem     = exp_reg >> sel_idx;
        cur_bit = rem[0];
        at_end  = (sel_idx == LAST_IDX) || ((CONST_TIME == 0) && (rem == '0));
        do_mul  = (CONST_TIME != 0) || rem[0];
    end

    // Main FSM: latch operands, issue one multiply per state, publish R on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            base_reg  <= '0;
            exp_reg   <= '0;
            prime_reg <= '0;
            r_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            mm_start  <= 1'b0;
        end else begin
            done     <= 1'b0;
            mm_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_reg  <= base;
                        exp_reg   <= exp_in;
                        prime_reg <= prime;
                        idx       <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        mm_start  <= (prime != '0);
                        state     <= PREP;
                    end
                end
                PREP: begin
                    if (prime_reg == '0) begin
                        r_reg <= '0;
                        state <= DONE;
                    end else if (mm_finished) begin
                        b_reg <= mm_y;
                        r_reg <= (prime_reg == W'(1)) ? '0 : W'(1);
                        if (at_end) begin
                            state <= DONE;
                        end else begin
                            mm_start <= 1'b1;
                            state    <= do_mul ? MUL : SQR;
                        end
                    end
                end
                MUL: begin
                    if (mm_finished) begin
                        if (cur_bit) begin
                            r_reg <= mm_y;
                        end
                        mm_start <= 1'b1;
                        state    <= SQR;
                    end
                end
                SQR: begin
                    if (mm_finished) begin
                        b_reg <= mm_y;
                        idx   <= idx + IW'(1);
                        if (at_end) begin
                            state <= DONE;
                        end else begin
                            mm_start <= 1'b1;
                            state    <= do_mul ? MUL : SQR;
                        end
                    end
                end
                DONE: begin
                    result <= r_reg;
                    err    <= (prime_reg == '0);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
